// File: rtl/count_compare_unit.sv
// ============================================================================
// count_compare_unit : compare/event stage behind the free-running counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module count_compare_unit #(
  parameter int WIDTH  = 16,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_target,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_periodic,
  input  logic              arm,
  input  logic              disarm,
  input  logic              evt_ack,
  output logic              evt_pulse,
  output logic              evt_pending,
  output logic              overrun,
  output logic [ECNT_W-1:0] event_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic                periodic_q, periodic_d;
  logic                evt_pulse_q, evt_pulse_d;
  logic                evt_pending_q, evt_pending_d;
  logic                overrun_q, overrun_d;
  logic [ECNT_W-1:0]   event_cnt_q, event_cnt_d;

  logic                cfg_fire;
  logic                match;

  assign cfg_ready = (state_q == IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;
  // disarm suppresses the match outright, so a same-cycle hit leaves no trace
  assign match     = (state_q == ARMED) && !disarm && (count_in == target_q);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    period_d      = period_q;
    periodic_d    = periodic_q;
    evt_pulse_d   = 1'b0;
    evt_pending_d = evt_pending_q;
    overrun_d     = overrun_q;
    event_cnt_d   = event_cnt_q;

    if (match) begin
      evt_pulse_d   = 1'b1;
      evt_pending_d = 1'b1;
      if (evt_pending_q && !evt_ack)
        overrun_d = 1'b1;
      if (event_cnt_q != {ECNT_W{1'b1}})
        event_cnt_d = event_cnt_q + 1'b1;
      // period 0 leaves the target alone: next hit is one full counter lap away
      if (periodic_q)
        target_d = target_q + period_q;
    end else if (evt_ack) begin
      evt_pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          target_d    = cfg_target;
          period_d    = cfg_period;
          periodic_d  = cfg_periodic;
          event_cnt_d = '0;
          overrun_d   = 1'b0;
        end
        if (arm && !disarm)
          state_d = ARMED;
      end
      ARMED: begin
        if (disarm)
          state_d = IDLE;
        else if (match && !periodic_q)
          state_d = DONE;
      end
      DONE: begin
        if (disarm)
          state_d = IDLE;
        else if (arm)
          state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      target_q      <= '0;
      period_q      <= '0;
      periodic_q    <= 1'b0;
      evt_pulse_q   <= 1'b0;
      evt_pending_q <= 1'b0;
      overrun_q     <= 1'b0;
      event_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      period_q      <= period_d;
      periodic_q    <= periodic_d;
      evt_pulse_q   <= evt_pulse_d;
      evt_pending_q <= evt_pending_d;
      overrun_q     <= overrun_d;
      event_cnt_q   <= event_cnt_d;
    end
  end

  assign evt_pulse   = evt_pulse_q;
  assign evt_pending = evt_pending_q;
  assign overrun     = overrun_q;
  assign event_cnt   = event_cnt_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_count_compare_unit.sv
// ============================================================================
// tb_count_compare_unit : directed vector table plus multi-cycle sequences
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_count_compare_unit;

  logic        clk;
  logic        reset;
  logic [15:0] count_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_target;
  logic [15:0] cfg_period;
  logic        cfg_periodic;
  logic        arm;
  logic        disarm;
  logic        evt_ack;
  logic        evt_pulse;
  logic        evt_pending;
  logic        overrun;
  logic [7:0]  event_cnt;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  count_compare_unit #(.WIDTH(16), .ECNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_target   (cfg_target),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .arm          (arm),
    .disarm       (disarm),
    .evt_ack      (evt_ack),
    .evt_pulse    (evt_pulse),
    .evt_pending  (evt_pending),
    .overrun      (overrun),
    .event_cnt    (event_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [15:0] tgt;
    logic [15:0] per;
    logic        prd;
    logic        arm;
    logic        dis;
    logic        ack;
    logic [15:0] cnt;
    logic        e_pulse;
    logic        e_pend;
    logic        e_ovr;
    logic [7:0]  e_ecnt;
    logic [1:0]  e_state;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cv, logic [15:0] tgt, logic prd, logic a, logic d,
                              logic k, logic [15:0] cnt, logic p, logic pe, logic ov,
                              logic [7:0] ec, logic [1:0] st, logic rdy);
    vec_t v;
    v.cv = cv; v.tgt = tgt; v.per = 16'h0; v.prd = prd; v.arm = a; v.dis = d;
    v.ack = k; v.cnt = cnt; v.e_pulse = p; v.e_pend = pe; v.e_ovr = ov;
    v.e_ecnt = ec; v.e_state = st; v.e_ready = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; arm = 0; disarm = 0; evt_ack = 0;
  endtask

  task automatic configure(input logic [15:0] tgt, input logic [15:0] per, input logic prd);
    idle_inputs();
    cfg_valid = 1; cfg_target = tgt; cfg_period = per; cfg_periodic = prd; evt_ack = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    logic [13:0] act_b, exp_b;
    int          events;
    logic        exp_p;

    reset = 1; count_in = 0; cfg_target = 0; cfg_period = 0; cfg_periodic = 0;
    idle_inputs();

    // One-shot, re-arm, ack and collision vectors; expected = state after the edge
    //                cv tgt     prd a d k cnt      p pe ov ec st    rdy
    vecs.push_back(mk(1, 16'h10, 0, 0,0,0, 16'h00, 0,0, 0, 0, 2'd0, 1));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h08, 0,0, 0, 0, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h09, 0,0, 0, 0, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h0F, 0,0, 0, 0, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h10, 1,1, 0, 1, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h11, 0,1, 0, 1, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h10, 0,1, 0, 1, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,1, 16'h00, 0,0, 0, 1, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,1,0, 16'h00, 0,0, 0, 1, 2'd0, 1));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,0, 0, 1, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,1,0, 16'h10, 0,0, 0, 1, 2'd0, 1));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,0, 0, 1, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h10, 1,1, 0, 2, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,1, 0, 2, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,1, 16'h10, 1,1, 0, 3, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,1, 0, 3, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,1, 0, 3, 2'd1, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,0, 16'h10, 1,1, 1, 4, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,0,1, 16'h00, 0,0, 1, 4, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 1,0,0, 16'h00, 0,0, 1, 4, 2'd1, 0));
    vecs.push_back(mk(1, 16'h50, 0, 0,0,0, 16'h10, 1,1, 1, 5, 2'd2, 0));
    vecs.push_back(mk(0, 16'h00, 0, 0,1,0, 16'h00, 0,1, 1, 5, 2'd0, 1));
    vecs.push_back(mk(1, 16'h20, 0, 0,0,0, 16'h00, 0,1, 0, 0, 2'd0, 1));
    vecs.push_back(mk(0, 16'h00, 0, 1,1,0, 16'h00, 0,1, 0, 0, 2'd0, 1));

    // Reset state
    #12;
    chk("reset_outputs", {evt_pulse, evt_pending, overrun, event_cnt, state, cfg_ready},
        {1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b1});
    reset = 0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_valid = vecs[i].cv; cfg_target = vecs[i].tgt; cfg_period = vecs[i].per;
      cfg_periodic = vecs[i].prd; arm = vecs[i].arm; disarm = vecs[i].dis;
      evt_ack = vecs[i].ack; count_in = vecs[i].cnt;
      tick();
      act_b = {evt_pulse, evt_pending, overrun, event_cnt, state, cfg_ready};
      exp_b = {vecs[i].e_pulse, vecs[i].e_pend, vecs[i].e_ovr, vecs[i].e_ecnt,
               vecs[i].e_state, vecs[i].e_ready};
      chk($sformatf("vec%0d", i), {18'd0, act_b}, {18'd0, exp_b});
    end
    idle_inputs();

    // Periodic: hits at 5, 9, 0xD, ... 0x1D while sweeping 0..0x20
    configure(16'h0005, 16'h0004, 1'b1);
    count_in = 0; arm = 1; tick(); arm = 0;
    events = 0;
    for (int c = 0; c <= 32'h20; c++) begin
      count_in = c[15:0];
      tick();
      exp_p = (c == 5) || (c == 9) || (c == 13) || (c == 17) || (c == 21) ||
              (c == 25) || (c == 29);
      if (exp_p) events++;
      chk($sformatf("per_pulse_%0h", c), {31'd0, evt_pulse}, {31'd0, exp_p});
      chk($sformatf("per_ovr_%0h", c), {31'd0, overrun}, {31'd0, events >= 2});
    end
    chk("per_event_cnt", {24'd0, event_cnt}, 32'd7);

    // Wrap: FFFE -> 0001 -> 0004
    disarm = 1; tick(); disarm = 0;
    configure(16'hFFFE, 16'h0003, 1'b1);
    arm = 1; tick(); arm = 0;
    for (int c = 32'hFFF8; c <= 32'h10005; c++) begin
      count_in = c[15:0];
      tick();
      exp_p = (c == 32'hFFFE) || (c == 32'h10001) || (c == 32'h10004);
      chk($sformatf("wrap_pulse_%0h", c[15:0]), {31'd0, evt_pulse}, {31'd0, exp_p});
    end
    chk("wrap_event_cnt", {24'd0, event_cnt}, 32'd3);

    // Period 0 keeps the target; then async reset mid-ARMED one count before the hit
    disarm = 1; tick(); disarm = 0;
    configure(16'h1234, 16'h0000, 1'b1);
    arm = 1; tick(); arm = 0;
    count_in = 16'h1234; tick();
    chk("p0_first", {evt_pulse, event_cnt}, {1'b1, 8'd1});
    tick();
    chk("p0_second", {evt_pulse, overrun, event_cnt}, {1'b1, 1'b1, 8'd2});
    count_in = 16'h1233; tick();
    chk("pre_reset", {evt_pulse, state}, {1'b0, 2'b01});
    count_in = 16'h1234;
    #2 reset = 1;
    #1;
    chk("async_reset", {evt_pulse, evt_pending, overrun, event_cnt, state, cfg_ready},
        {1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b1});
    tick();
    chk("reset_no_pulse", {evt_pulse, state, event_cnt}, {1'b0, 2'b00, 8'd0});
    reset = 0;
    tick();
    chk("post_reset_idle", {evt_pulse, state}, {1'b0, 2'b00});

    // Saturation: period 1 tracking the counter hits every cycle
    configure(16'h0000, 16'h0001, 1'b1);
    count_in = 0; arm = 1; tick(); arm = 0;
    for (int c = 0; c < 300; c++) begin
      count_in = c[15:0];
      tick();
      if (c == 253) chk("sat_pre", {24'd0, event_cnt}, 32'd254);
    end
    chk("sat_final", {evt_pulse, event_cnt}, {1'b1, 8'hFF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
